hex_display_scanner: RTL and testbench



---
 rtl/hex_display_pkg.sv | 34 +++
 rtl/hex_display_scanner_if.sv | 26 ++
 rtl/hex_to_sevenseg.sv | 12 +
 rtl/hex_display_scanner.sv | 109 ++++++++++
 tb/tb_hex_display_scanner.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for 7-segment hex display drivers.
// Contents: segment encodings (active-low {g,f,e,d,c,b,a}), digit index
// type, and the leading-zero test used by the scanner.
package hex_display_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned HEX_W      = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low hex glyphs, index = nibble value
    localparam logic [0:15][SEG_W-1:0] SEG_HEX = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [1:0] digit_idx_t;

    // True when digit idx and every digit to its left are zero; digit 0 never qualifies
    function automatic logic lead_zero(input logic [HEX_W-1:0] val, input digit_idx_t idx);
        logic z;
        z = 1'b0;
        case (idx)
            2'd3:    z = (val[15:12] == 4'h0);
            2'd2:    z = (val[15:8]  == 8'h00);
            2'd1:    z = (val[15:4]  == 12'h000);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Bus between the hex-digits PIO side and the display scanner.
// master: drives display word / controls, observes pins.
// slave : the scanner; drives segment, decimal point, anode pins and frame_tick.
interface hex_display_scanner_if;
    import hex_display_pkg::*;

    logic [HEX_W-1:0]      hex_value;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic                  blank_leading;
    logic                  display_en;
    logic [SEG_W-1:0]      seg_n;
    logic                  dp_n;
    logic [NUM_DIGITS-1:0] digit_sel_n;
    logic                  frame_tick;

    modport master (
        output hex_value, dp_mask, blank_leading, display_en,
        input  seg_n, dp_n, digit_sel_n, frame_tick
    );

    modport slave (
        input  hex_value, dp_mask, blank_leading, display_en,
        output seg_n, dp_n, digit_sel_n, frame_tick
    );

endinterface

// File: rtl/hex_to_sevenseg.sv
// Combinational nibble to active-low 7-segment decoder.
// Ports: nibble_i (4b hex digit), seg_c_o (7b active-low {g,f,e,d,c,b,a}).
module hex_to_sevenseg
    import hex_display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble_i,
    output logic [SEG_W-1:0]    seg_c_o
);

    assign seg_c_o = SEG_HEX[nibble_i];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 4-digit common-anode 7-segment driver.
// Ports: clk, reset (async, active-high); bus (slave modport) carrying
// hex_value/dp_mask/blank_leading/display_en in and seg_n/dp_n/digit_sel_n/
// frame_tick out. All outputs registered, one cycle behind scan state.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_scanner_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    digit_idx_t            idx_q, idx_d;
    logic [HEX_W-1:0]      sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic                  sh_bl_q, sh_bl_d;

    logic [SEG_W-1:0]      seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] digit_sel_n_q, digit_sel_n_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  slot_end_c;
    logic                  frame_end_c;
    logic [NIBBLE_W-1:0]   nibble_c;
    logic [SEG_W-1:0]      glyph_c;

    // Decode the digit currently being scanned
    assign nibble_c = sh_val_q[{idx_q, 2'b00} +: NIBBLE_W];

    hex_to_sevenseg u_dec (
        .nibble_i (nibble_c),
        .seg_c_o  (glyph_c)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            sh_val_q      <= '0;
            sh_dp_q       <= '0;
            sh_bl_q       <= 1'b0;
            seg_n_q       <= SEG_BLANK;
            dp_n_q        <= 1'b1;
            digit_sel_n_q <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            sh_val_q      <= sh_val_d;
            sh_dp_q       <= sh_dp_d;
            sh_bl_q       <= sh_bl_d;
            seg_n_q       <= seg_n_d;
            dp_n_q        <= dp_n_d;
            digit_sel_n_q <= digit_sel_n_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    // Prescaler, digit index and once-per-frame shadow load
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_bl_d  = sh_bl_q;

        slot_end_c  = (cnt_q == CNT_W'(SCAN_DIV - 1));
        frame_end_c = slot_end_c && (idx_q == 2'd3);

        if (slot_end_c) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        if (frame_end_c) begin
            sh_val_d = bus.hex_value;
            sh_dp_d  = bus.dp_mask;
            sh_bl_d  = bus.blank_leading;
        end
    end

    // Pin values for the next cycle; anodes stay dark during the anti-ghost window
    always_comb begin
        seg_n_d       = glyph_c;
        dp_n_d        = ~sh_dp_q[idx_q];
        digit_sel_n_d = '1;
        frame_tick_d  = frame_end_c;

        if (sh_bl_q && lead_zero(sh_val_q, idx_q)) begin
            seg_n_d = SEG_BLANK;
        end
        if (bus.display_en && (cnt_q >= CNT_W'(BLANK_CYCLES))) begin
            digit_sel_n_d = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    assign bus.seg_n       = seg_n_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.digit_sel_n = digit_sel_n_q;
    assign bus.frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (SCAN_DIV=4, BLANK_CYCLES=1).
// Reference model derives scan position from the cycle number since reset
// and holds the frame snapshot taken at each frame boundary.
module tb_hex_display_scanner;

    localparam int D = 4;
    localparam int B = 1;
    localparam int FRAME = 4 * D;

    logic clk;
    logic reset;

    hex_display_scanner_if bus ();

    hex_display_scanner #(
        .SCAN_DIV     (D),
        .BLANK_CYCLES (B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_ref [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_cmp = 0;
    int n_bad = 0;

    int          k;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_bl;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_seg"},  {1'b0, bus.seg_n},       8'h7F);
        chk({tag, "_dp"},   {7'b0, bus.dp_n},        8'h01);
        chk({tag, "_sel"},  {4'b0, bus.digit_sel_n}, 8'h0F);
        chk({tag, "_tick"}, {7'b0, bus.frame_tick},  8'h00);
    endtask

    task automatic model_reset();
        k     = 0;
        m_val = '0;
        m_dp  = '0;
        m_bl  = 1'b0;
    endtask

    // One clock: predict outputs from scan position k, then compare after the edge
    task automatic tick();
        int          cnt;
        int          idx;
        logic [15:0] hi;
        logic [3:0]  e_sel;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_tick;
        cnt    = k % D;
        idx    = (k / D) % 4;
        hi     = m_val >> (4 * idx);
        e_sel  = (bus.display_en && cnt >= B) ? ~(4'b0001 << idx) : 4'hF;
        e_seg  = (m_bl && idx != 0 && hi == 16'h0) ? 7'h7F : seg_ref[hi[3:0]];
        e_dp   = ~m_dp[idx];
        e_tick = (k % FRAME) == FRAME - 1;
        @(posedge clk);
        #1;
        if (e_tick) begin
            m_val = bus.hex_value;
            m_dp  = bus.dp_mask;
            m_bl  = bus.blank_leading;
        end
        k++;
        chk("seg_n",       {1'b0, bus.seg_n},       {1'b0, e_seg});
        chk("dp_n",        {7'b0, bus.dp_n},        {7'b0, e_dp});
        chk("digit_sel_n", {4'b0, bus.digit_sel_n}, {4'b0, e_sel});
        chk("frame_tick",  {7'b0, bus.frame_tick},  {7'b0, e_tick});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset             = 1'b1;
        bus.hex_value     = 16'h1234;
        bus.dp_mask       = 4'b0000;
        bus.blank_leading = 1'b0;
        bus.display_en    = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst_hold");
        @(negedge clk);
        reset = 1'b0;

        // Frame 0 shows shadow 0000, frame tick after cycle 15, then 1234
        run(2 * FRAME + 4);

        // Leading-zero blanking
        bus.hex_value     = 16'h00A0;
        bus.blank_leading = 1'b1;
        run(2 * FRAME);
        bus.hex_value = 16'h0000;
        run(2 * FRAME);

        // Mid-frame change is held off until the next boundary
        bus.blank_leading = 1'b0;
        bus.hex_value     = 16'hFFFF;
        while ((k % FRAME) != 0) tick();
        run(FRAME + 6);
        bus.hex_value = 16'h8888;
        run(FRAME);

        // Decimal points survive leading-zero blanking
        bus.hex_value     = 16'h0000;
        bus.blank_leading = 1'b1;
        bus.dp_mask       = 4'b0101;
        run(2 * FRAME);

        // Display disable: anodes dark, scan timing undisturbed
        bus.hex_value  = 16'h0C0D;
        bus.display_en = 1'b0;
        run(10);
        bus.display_en = 1'b1;
        run(2 * FRAME);

        // Randomized inputs, with varying counts of leading zeros
        for (int i = 0; i < 30; i++) begin
            logic [15:0] r;
            int          nz;
            r  = 16'($urandom);
            nz = $urandom_range(0, 4);
            bus.hex_value     = (nz == 0) ? 16'h0 : (r >> (4 * (4 - nz)));
            bus.dp_mask       = 4'($urandom);
            bus.blank_leading = 1'($urandom);
            bus.display_en    = ($urandom_range(0, 3) != 0);
            run($urandom_range(1, 24));
        end
        bus.display_en = 1'b1;

        // Async reset during digit 2's slot
        bus.hex_value = 16'h4321;
        while ((k % FRAME) != 2 * D + 1) tick();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        @(posedge clk);
        #1;
        chk_reset_vals("rst_async_hold");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(2 * FRAME + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
